// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, flag layout and shared constants for alu32_flags
package alu_pkg;

    localparam int WIDTH  = 32;
    localparam int SHAMT_W = 5;
    localparam int CC_BIT = 4;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_AND  = 6'b000001;
    localparam logic [5:0] OP_OR   = 6'b000010;
    localparam logic [5:0] OP_XOR  = 6'b000011;
    localparam logic [5:0] OP_SUB  = 6'b000100;
    localparam logic [5:0] OP_ANDN = 6'b000101;
    localparam logic [5:0] OP_ORN  = 6'b000110;
    localparam logic [5:0] OP_XNOR = 6'b000111;
    localparam logic [5:0] OP_ADDX = 6'b001000;
    localparam logic [5:0] OP_SUBX = 6'b001100;
    localparam logic [5:0] OP_SLL  = 6'b100101;
    localparam logic [5:0] OP_SRL  = 6'b100110;
    localparam logic [5:0] OP_SRA  = 6'b100111;

    // Bit positions of the flags when packed as {n, z, v, c}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/alu32_addsub.sv
// rtl/alu32_addsub.sv - 33-bit add/subtract core producing sum, carry/borrow and overflow
module alu32_addsub
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH:0]   sum33;

    // A - B - cin is computed as A + ~B + !cin; the borrow is then the
    // inverted carry out of the top bit.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;
    assign sum33   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};

    assign sum   = sum33[WIDTH-1:0];
    assign carry = sub ? ~sum33[WIDTH] : sum33[WIDTH];

    // Overflow when the effective operands share a sign the result does not.
    assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu32_flags.sv
// rtl/alu32_flags.sv - 32-bit integer ALU with registered N/Z/V/C condition codes
module alu32_flags
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [5:0]       opcode,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             c
);

    logic [5:0]         base_op;
    logic [SHAMT_W-1:0] shamt;
    logic               as_sub;
    logic               as_cin;
    logic [WIDTH-1:0]   as_sum;
    logic               as_carry;
    logic               as_ovf;
    logic               op_valid;
    logic               op_arith;
    logic               cc_load;
    flags_t             flags_d;
    flags_t             flags_q;

    // Fold the set-cc variants onto their base code; shift codes keep bit5.
    assign base_op = opcode[5] ? opcode : {2'b00, opcode[3:0]};
    assign shamt   = b_in[SHAMT_W-1:0];

    // Bit2 of the low code selects subtract for SUB/SUBX, bit3 selects the
    // X variants that consume carry_in; other ops ignore the adder output.
    assign as_sub = opcode[2];
    assign as_cin = opcode[3] ? carry_in : 1'b0;

    alu32_addsub u_addsub (
        .a     (a_in),
        .b     (b_in),
        .sub   (as_sub),
        .cin   (as_cin),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    always_comb begin
        result   = '0;
        op_valid = 1'b1;
        op_arith = 1'b0;
        case (base_op)
            OP_ADD, OP_ADDX,
            OP_SUB, OP_SUBX: begin
                result   = as_sum;
                op_arith = 1'b1;
            end
            OP_AND:  result = a_in & b_in;
            OP_OR:   result = a_in | b_in;
            OP_XOR:  result = a_in ^ b_in;
            OP_ANDN: result = a_in & ~b_in;
            OP_ORN:  result = a_in | ~b_in;
            OP_XNOR: result = ~(a_in ^ b_in);
            OP_SLL:  result = a_in << shamt;
            OP_SRL:  result = a_in >> shamt;
            OP_SRA:  result = $unsigned($signed(a_in) >>> shamt);
            default: op_valid = 1'b0;
        endcase
    end

    // Shifts live at bit5=1, so they can never hit the cc path.
    assign cc_load = op_valid && !opcode[5] && opcode[CC_BIT];

    always_comb begin
        flags_d   = '0;
        flags_d.n = result[WIDTH-1];
        flags_d.z = (result == '0);
        flags_d.v = op_arith ? as_ovf   : 1'b0;
        flags_d.c = op_arith ? as_carry : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (cc_load) begin
            flags_q <= flags_d;
        end
    end

    assign n = flags_q.n;
    assign z = flags_q.z;
    assign v = flags_q.v;
    assign c = flags_q.c;

endmodule

// File: tb/tb_alu32_flags.sv
// tb/tb_alu32_flags.sv - self-checking bench for alu32_flags
module tb_alu32_flags;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [5:0]  opcode;
    logic        carry_in;
    logic [31:0] result;
    logic        n, z, v, c;

    int total = 0;
    int bad   = 0;

    logic [3:0] mflags;

    always #5 clk = ~clk;

    alu32_flags dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_in     (a_in),
        .b_in     (b_in),
        .opcode   (opcode),
        .carry_in (carry_in),
        .result   (result),
        .n        (n),
        .z        (z),
        .v        (v),
        .c        (c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the opcode meaning.
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, output logic [31:0] res, output logic wr,
                         output logic [3:0] f);
        logic [32:0] wide;
        logic [32:0] rhs;
        logic        valid;
        logic        fv, fc;
        int          sh;
        res   = 32'h0;
        valid = 1'b1;
        fv    = 1'b0;
        fc    = 1'b0;
        sh    = int'(b[4:0]);
        if (op[5]) begin
            case (op)
                6'b100101: res = a << sh;
                6'b100110: res = a >> sh;
                6'b100111: res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                default:   valid = 1'b0;
            endcase
            wr = 1'b0;
        end else begin
            case (op[3:0])
                4'h0, 4'h8: begin
                    wide = {1'b0, a} + {1'b0, b} + ((op[3:0] == 4'h8) ? {32'h0, cin} : 33'h0);
                    res  = wide[31:0];
                    fc   = wide[32];
                    fv   = (a[31] == b[31]) && (res[31] != a[31]);
                end
                4'h4, 4'hC: begin
                    rhs = {1'b0, b} + ((op[3:0] == 4'hC) ? {32'h0, cin} : 33'h0);
                    res = a - rhs[31:0];
                    fc  = ({1'b0, a} < rhs);
                    fv  = (a[31] != b[31]) && (res[31] != a[31]);
                end
                4'h1: res = a & b;
                4'h2: res = a | b;
                4'h3: res = a ^ b;
                4'h5: res = a & ~b;
                4'h6: res = a | ~b;
                4'h7: res = ~(a ^ b);
                default: valid = 1'b0;
            endcase
            wr = valid && op[4];
        end
        f = {res[31], res == 32'h0, fv, fc};
    endtask

    // Drive one operation, check the combinational result, then the flags after the edge.
    task automatic apply_rand(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic cin);
        logic [31:0] res;
        logic        wr;
        logic [3:0]  f;
        opcode = op; a_in = a; b_in = b; carry_in = cin;
        #1;
        model(op, a, b, cin, res, wr, f);
        check($sformatf("rnd_res op=%b", op), result, res);
        if (wr) mflags = f;
        @(posedge clk);
        #1;
        check($sformatf("rnd_flags op=%b", op), {28'h0, n, z, v, c}, {28'h0, mflags});
    endtask

    task automatic apply_dir(input string tag, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic cin,
                             input logic [31:0] exp_res, input logic [3:0] exp_flags);
        opcode = op; a_in = a; b_in = b; carry_in = cin;
        #1;
        check({tag, "_res"}, result, exp_res);
        @(posedge clk);
        #1;
        check({tag, "_flags"}, {28'h0, n, z, v, c}, {28'h0, exp_flags});
        mflags = exp_flags;
    endtask

    logic [5:0]  op_tab [23];
    logic [31:0] corner [6];

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        op_tab = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h0C,
                   6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h1C,
                   6'h25, 6'h26, 6'h27};
        corner = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'hFFFF_FFFE};

        rst_n = 1'b0; a_in = 32'h0; b_in = 32'h0; opcode = 6'h11; carry_in = 1'b0;
        mflags = 4'h0;
        #2;
        check("reset_flags", {28'h0, n, z, v, c}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        apply_dir("and_nocc",  6'b000001, 32'hF0, 32'hFF, 1'b0, 32'hF0, 4'b0000);
        apply_dir("andcc",     6'b010001, 32'hF0, 32'hFF, 1'b0, 32'hF0, 4'b0000);
        apply_dir("andncc",    6'b010101, 32'h0,  32'hFF, 1'b0, 32'h0,  4'b0100);
        apply_dir("addxcc",    6'b011000, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 4'b0101);
        apply_dir("add_nocc",  6'b000000, 32'h1, 32'h1, 1'b0, 32'h2, 4'b0101);
        apply_dir("subcc",     6'b010100, 32'h1, 32'h2, 1'b0, 32'hFFFF_FFFF, 4'b1001);
        apply_dir("subxcc",    6'b011100, 32'hEFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hF000_0000, 4'b1001);
        apply_dir("addcc_ovf", 6'b010000, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 4'b1010);
        apply_dir("subcc_ovf", 6'b010100, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 4'b0010);
        apply_dir("sll1",      6'b100101, 32'h1, 32'h1, 1'b0, 32'h2, 4'b0010);
        apply_dir("srl1",      6'b100110, 32'h1, 32'h1, 1'b0, 32'h0, 4'b0010);
        apply_dir("sra4",      6'b100111, 32'h8000_0000, 32'h4, 1'b0, 32'hF800_0000, 4'b0010);
        apply_dir("sra1",      6'b100111, 32'h2, 32'h1, 1'b0, 32'h1, 4'b0010);
        apply_dir("sll0_hib",  6'b100101, 32'h1234_5678, 32'hFFFF_FFE0, 1'b1, 32'h1234_5678, 4'b0010);
        apply_dir("srl31",     6'b100110, 32'h8000_0000, 32'h1F, 1'b0, 32'h1, 4'b0010);
        apply_dir("sra31",     6'b100111, 32'h8000_0000, 32'hABCD_EF1F, 1'b0, 32'hFFFF_FFFF, 4'b0010);
        apply_dir("addxcc_wr", 6'b011000, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 4'b0101);
        apply_dir("addcc_cin", 6'b010000, 32'h1, 32'h1, 1'b1, 32'h2, 4'b0000);
        apply_dir("subxcc_c",  6'b011100, 32'h5, 32'h2, 1'b1, 32'h2, 4'b0000);
        apply_dir("bad_op",    6'b011001, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 4'b0000);
        apply_dir("setflags",  6'b010100, 32'h1, 32'h2, 1'b0, 32'hFFFF_FFFF, 4'b1001);
        apply_dir("bad_shcc",  6'b110101, 32'h1, 32'h1, 1'b0, 32'h0, 4'b1001);

        // Asynchronous reset mid-cycle with an update pending.
        opcode = 6'b010000; a_in = 32'h7FFF_FFFF; b_in = 32'h1; carry_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_flags", {28'h0, n, z, v, c}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_flags", {28'h0, n, z, v, c}, 32'h0);
        rst_n = 1'b1;
        mflags = 4'h0;

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else op = op_tab[$urandom_range(0, 22)];
            apply_rand(op, pick_operand(), pick_operand(), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
